// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage and its pipeline register.
package cpu_pkg;

    localparam int          ADDR_W     = 32;
    localparam int          INSTR_W    = 32;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

    // Fetch FSM: RUN fetches sequentially, HALT parks the PC until a redirect.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, its PC, PC+4 and a valid flag.
// Flush beats stall, stall beats the halted bubble, otherwise a fresh capture.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int ADDR_W  = cpu_pkg::ADDR_W,
    parameter int INSTR_W = cpu_pkg::INSTR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush_i,
    input  logic               stall_i,
    input  logic               halted_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    input  logic [ADDR_W-1:0]  pc4_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [ADDR_W-1:0]  pc4_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc4_q, pc4_d;
    logic               valid_q, valid_d;

    // Next-state selection with flush > stall > halted > capture priority.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = INSTR_W'(NOP_INSTR);
            pc_d    = '0;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (stall_i) begin
            valid_d = valid_q;
        end else if (halted_i) begin
            // Halted: keep the last fields for debug visibility, but mark them stale.
            valid_d = 1'b0;
        end else begin
            instr_d = instr_i;
            pc_d    = pc_i;
            pc4_d   = pc4_i;
            valid_d = 1'b1;
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q <= '0;
            pc_q    <= '0;
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc4_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the combinational instruction memory and
// feeds the IF/ID register. Handles stall, flush, branch redirect and HALT.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int                  ADDR_W     = cpu_pkg::ADDR_W,
    parameter int                  INSTR_W    = cpu_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0]   RESET_PC   = ADDR_W'(cpu_pkg::RESET_PC),
    parameter logic [INSTR_W-1:0]  HALT_INSTR = INSTR_W'(cpu_pkg::HALT_INSTR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic               branch_taken_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [ADDR_W-1:0]  if_id_pc_o,
    output logic [ADDR_W-1:0]  if_id_pc4_o,
    output logic               if_id_valid_o,
    output logic               halted_o,
    output logic               misalign_o,
    output logic [31:0]        fetch_count_o
);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              misalign_q, misalign_d;
    logic [31:0]       count_q, count_d;

    logic              running;
    logic              capture;
    logic              halt_seen;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] target_aligned;

    assign running        = (state_q == RUN);
    // A real instruction enters IF/ID only when running, not stalled and not flushed.
    assign capture        = running && !stall_i && !flush_i;
    assign halt_seen      = capture && (imem_instr_i == HALT_INSTR);
    assign pc_plus4       = pc_q + ADDR_W'(4);
    // Low address bits are dropped; a misaligned target is only flagged, not trapped.
    assign target_aligned = {branch_target_i[ADDR_W-1:2], 2'b00};

    // PC selection: redirect > halt hold > stall hold > sequential.
    always_comb begin
        pc_d = pc_plus4;
        if (branch_taken_i) begin
            pc_d = target_aligned;
        end else if (!running || halt_seen || stall_i) begin
            pc_d = pc_q;
        end
    end

    // FSM, sticky misalign flag and capture counter next-state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (halt_seen) state_d = HALT;
            HALT:    if (branch_taken_i) state_d = RUN;
            default: state_d = RUN;
        endcase
        misalign_d = misalign_q | (branch_taken_i && (branch_target_i[1:0] != 2'b00));
        count_d    = capture ? count_q + 32'd1 : count_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush_i  (flush_i),
        .stall_i  (stall_i),
        .halted_i (!running),
        .instr_i  (imem_instr_i),
        .pc_i     (pc_q),
        .pc4_i    (pc_plus4),
        .instr_o  (if_id_instr_o),
        .pc_o     (if_id_pc_o),
        .pc4_o    (if_id_pc4_o),
        .valid_o  (if_id_valid_o)
    );

    assign imem_addr_o   = pc_q;
    assign halted_o      = (state_q == HALT);
    assign misalign_o    = misalign_q;
    assign fetch_count_o = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios followed by random traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, stall, flush, br;
    logic [31:0] tgt;
    logic [31:0] imem_addr, imem_instr;
    logic [31:0] ifid_instr, ifid_pc, ifid_pc4, count;
    logic        valid, halted, mis;

    int total = 0;
    int bad   = 0;

    // Memory image: HALT at 0x10, every other word distinct and never all-ones.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'hFFFF_FFFF;
        return a + 32'h1000_0000;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    instruction_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_taken_i  (br),
        .branch_target_i (tgt),
        .imem_addr_o     (imem_addr),
        .imem_instr_i    (imem_instr),
        .if_id_instr_o   (ifid_instr),
        .if_id_pc_o      (ifid_pc),
        .if_id_pc4_o     (ifid_pc4),
        .if_id_valid_o   (valid),
        .halted_o        (halted),
        .misalign_o      (mis),
        .fetch_count_o   (count)
    );

    // Reference model state (what the outputs should read after each edge).
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4, m_count;
    bit          m_valid, m_halted, m_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the stated rules, compare all outputs.
    task automatic step(input bit rn, input bit st, input bit fl, input bit b, input logic [31:0] t);
        logic [31:0] word;
        bit          accept, halt_now, was_halted;
        rst_n = rn; stall = st; flush = fl; br = b; tgt = t;
        word       = mem_word(m_pc);
        was_halted = m_halted;
        if (!rn) begin
            m_pc = 32'h0; m_instr = 0; m_ipc = 0; m_ipc4 = 0;
            m_valid = 0; m_halted = 0; m_mis = 0; m_count = 0;
        end else begin
            accept   = !was_halted && !st && !fl;
            halt_now = accept && (word == 32'hFFFF_FFFF);
            if (fl) begin
                m_instr = 0; m_ipc = 0; m_ipc4 = 0; m_valid = 0;
            end else if (st) begin
                // IF/ID keeps everything
            end else if (was_halted) begin
                m_valid = 0;
            end else begin
                m_instr = word; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_valid = 1;
                m_count = m_count + 1;
            end
            if (b && t[1:0] != 2'b00) m_mis = 1;
            m_halted = was_halted ? !b : halt_now;
            if (b)                                 m_pc = t & 32'hFFFF_FFFC;
            else if (!(was_halted || halt_now || st)) m_pc = m_pc + 4;
        end
        @(posedge clk);
        #1;
        chk("imem_addr", imem_addr, m_pc);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc", ifid_pc, m_ipc);
        chk("ifid_pc4", ifid_pc4, m_ipc4);
        chk("ifid_valid", {31'b0, valid}, {31'b0, m_valid});
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        chk("misalign", {31'b0, mis}, {31'b0, m_mis});
        chk("fetch_count", count, m_count);
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; br = 1'b0; tgt = '0;
        m_pc = 0; m_instr = 0; m_ipc = 0; m_ipc4 = 0;
        m_valid = 0; m_halted = 0; m_mis = 0; m_count = 0;

        // Reset for two cycles.
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, valid}, 32'h0);

        // Sequential fetch.
        step(1, 0, 0, 0, 0);
        chk("seq1_addr", imem_addr, 32'h4);
        chk("seq1_pc", ifid_pc, 32'h0);
        chk("seq1_cnt", count, 32'd1);
        step(1, 0, 0, 0, 0);

        // Stall three cycles at PC=8, then release.
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_pc", ifid_pc, 32'h4);
        chk("stall_cnt", count, 32'd2);
        step(1, 0, 0, 0, 0);
        chk("unstall_pc", ifid_pc, 32'h8);

        // Branch with flush to 0x40.
        step(1, 0, 1, 1, 32'h40);
        chk("br_addr", imem_addr, 32'h40);
        chk("br_valid", {31'b0, valid}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("br_pc", ifid_pc, 32'h40);

        // Misaligned target, then an aligned branch: flag stays set.
        step(1, 0, 0, 1, 32'h42);
        chk("mis_addr", imem_addr, 32'h40);
        chk("mis_flag", {31'b0, mis}, 32'h1);
        step(1, 0, 0, 0, 0);

        // Run into HALT at 0x10.
        step(1, 0, 1, 1, 32'h0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        chk("halt_instr", ifid_instr, 32'hFFFF_FFFF);
        chk("halt_flag", {31'b0, halted}, 32'h1);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        chk("halt_addr", imem_addr, 32'h10);
        chk("mis_sticky", {31'b0, mis}, 32'h1);
        step(1, 0, 1, 1, 32'h0);
        chk("unhalt", {31'b0, halted}, 32'h0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Wrap from the top of the address space.
        step(1, 0, 1, 1, 32'hFFFF_FFFC);
        step(1, 0, 0, 0, 0);
        chk("wrap_addr", imem_addr, 32'h0);
        step(1, 0, 0, 0, 0);

        // Reset mid-run.
        step(0, 0, 0, 1, 32'h80);
        chk("midrst_addr", imem_addr, 32'h0);
        chk("midrst_cnt", count, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit          r_rn, r_st, r_fl, r_br;
            logic [31:0] r_t;
            r_rn = ($urandom_range(0, 59) != 0);
            r_st = ($urandom_range(0, 3) == 0);
            r_fl = ($urandom_range(0, 5) == 0);
            r_br = ($urandom_range(0, 5) == 0);
            r_t  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 27));
            step(r_rn, r_st, r_fl, r_br, r_t);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
